// File: rtl/ibex_dmem_cache.sv
// ibex_dmem_cache
//
// Word-addressed data memory for the ibex LSU data port (req/gnt/rvalid),
// fronted by a direct-mapped, write-through, write-update cache of LINES
// entries. Load hits complete in a fixed time. Load misses add MISS_LAT stall
// cycles, so the load latency depends on the address.
//
// Handshake: a request is accepted only in IDLE, on a clock edge where req=1.
// At that edge we/be/addr/wdata are captured. Later changes on the inputs,
// including req dropping, have no effect. gnt pulses for one cycle, and the
// access is performed at the end of that cycle. rvalid pulses on the following
// cycle. rdata changes only at a load's gnt edge and is held after that.
//
// Ports:
//   clk, rst_ni          clock; synchronous active-low reset
//   sram_req             request (sampled in IDLE only)
//   sram_gnt             one-cycle grant pulse
//   sram_rvalid          one-cycle response pulse
//   sram_we              1 = store, 0 = load
//   sram_be              byte enables
//   sram_addr            word address
//   sram_wdata           store data
//   sram_rdata           load data; bytes that are not enabled read as 0
//   lsu_addr_ctr         contract tap byte address
//   load_data_ctr        combinational mem[lsu_addr_ctr[AW+1:2]]
//   hit_cnt, miss_cnt    load hit/miss counters (only with DMEM_CACHE_STATS_EN)
//
// Optional feature: define DMEM_CACHE_STATS_EN to add the hit/miss counters.
module ibex_dmem_cache #(
    parameter int DEPTH    = 1024,
    parameter int AW       = $clog2(DEPTH),
    parameter int LINES    = 4,
    parameter int MISS_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          sram_req,
    output logic          sram_gnt,
    output logic          sram_rvalid,
    input  logic          sram_we,
    input  logic [3:0]    sram_be,
    input  logic [AW-1:0] sram_addr,
    input  logic [31:0]   sram_wdata,
    output logic [31:0]   sram_rdata,
    input  logic [31:0]   lsu_addr_ctr,
    output logic [31:0]   load_data_ctr
`ifdef DMEM_CACHE_STATS_EN
    ,
    output logic [31:0]   hit_cnt,
    output logic [31:0]   miss_cnt
`endif
);

    localparam int IW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int CW = $clog2(MISS_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        GNT  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state, state_next;

    // Transaction captured on acceptance
    logic          lat_we;
    logic [3:0]    lat_be;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [CW-1:0] miss_ctr;

    logic [31:0]   mem [DEPTH];

    // The tag holds the full word address. This matches the index+tag split,
    // and it also works when LINES=1, where the index has no bits.
    logic [LINES-1:0] line_valid;
    logic [AW-1:0]    line_tag  [LINES];
    logic [31:0]      line_data [LINES];

    function automatic logic [IW-1:0] idx_of(input logic [AW-1:0] a);
        if (LINES > 1) return a[IW-1:0];
        else           return '0;
    endfunction

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    logic [IW-1:0] req_idx, lat_idx;
    logic          req_hit, lat_hit;
    logic [31:0]   mask, mem_word, mem_store, line_store;

    assign req_idx = idx_of(sram_addr);
    // Hit decision taken in IDLE on the address that is being captured
    assign req_hit = !sram_we && line_valid[req_idx] && (line_tag[req_idx] == sram_addr);

    // The cache is not modified between acceptance and gnt, so recomputing
    // the lookup on the captured address gives the same result as in IDLE.
    assign lat_idx    = idx_of(lat_addr);
    assign lat_hit    = line_valid[lat_idx] && (line_tag[lat_idx] == lat_addr);
    assign mask       = be_mask(lat_be);
    assign mem_word   = mem[lat_addr];
    assign mem_store  = (mem_word & ~mask) | (lat_wdata & mask);
    assign line_store = (line_data[lat_idx] & ~mask) | (lat_wdata & mask);

    assign load_data_ctr = mem[lsu_addr_ctr[AW+1:2]];

    logic unused_ctr_bits;
    assign unused_ctr_bits = ^{lsu_addr_ctr[31:AW+2], lsu_addr_ctr[1:0]};

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next  = state;
        sram_gnt    = 1'b0;
        sram_rvalid = 1'b0;
        case (state)
            IDLE: begin
                if (sram_req) begin
                    if (!sram_we && !req_hit) state_next = MISS;
                    else                      state_next = GNT;
                end
            end
            MISS: begin
                if (miss_ctr == '0) state_next = GNT;
            end
            GNT: begin
                sram_gnt   = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                sram_rvalid = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            line_valid <= '0;
            sram_rdata <= '0;
            miss_ctr   <= '0;
            lat_we     <= 1'b0;
            lat_be     <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sram_req) begin
                        lat_we    <= sram_we;
                        lat_be    <= sram_be;
                        lat_addr  <= sram_addr;
                        lat_wdata <= sram_wdata;
                        miss_ctr  <= CW'(MISS_LAT - 1);
                    end
                end
                MISS: begin
                    if (miss_ctr != '0) miss_ctr <= miss_ctr - CW'(1);
                end
                GNT: begin
                    if (lat_we) begin
                        // Write-update: only a resident line is refreshed. A store miss does not allocate.
                        if (lat_hit) line_data[lat_idx] <= line_store;
                    end else if (lat_hit) begin
                        sram_rdata <= line_data[lat_idx] & mask;
                    end else begin
                        // Refill with the full word even when be masks part or all of it
                        sram_rdata           <= mem_word & mask;
                        line_valid[lat_idx]  <= 1'b1;
                        line_tag[lat_idx]    <= lat_addr;
                        line_data[lat_idx]   <= mem_word;
                    end
                end
                default: ;
            endcase
        end
    end

    // The memory array has no reset. A reset edge only blocks the write.
    always_ff @(posedge clk) begin
        if (rst_ni && (state == GNT) && lat_we) mem[lat_addr] <= mem_store;
    end

`ifdef DMEM_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if ((state == IDLE) && sram_req && !sram_we) begin
            if (req_hit) hit_cnt  <= hit_cnt + 32'd1;
            else         miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule
